sec_engine_scheduler: RTL
=========================

// Module: sec_engine_scheduler
// PURPOSE
//  Multi-channel front end for the shared crypto engine (SHA256 / Camellia) of the security module.
//  Round-robin arbitrates NUM_CH requesters and gates each request on a per-channel PUF authorisation bit.
//  Issues one start/done transaction to the engine, with a timeout watchdog.
//  Returns a tagged response carrying a status code, and counts failures.
// PARAMETERS
//  NUM_CH       4     number of requesting channels (>=2)
//  DW           128   request/response data width (bits)
//  TIMEOUT_CYC  1024  max cycles spent in WAIT before abort (>=2)
//  CW           $clog2(NUM_CH)  channel index width (derived, localparam)
// PORTS
//  clk          in   1          single clock, all logic on posedge
//  nreset       in   1          asynchronous, active-low reset
//  req_valid    in   NUM_CH     per-channel request valid
//  req_ready    out  NUM_CH     per-channel accept; one-hot or zero
//  req_op       in   2*NUM_CH   per-channel op: 00 HASH, 01 ENC, 10 DEC, 11 reserved; ch i at [2i+1:2i]
//  req_data     in   DW*NUM_CH  per-channel payload; ch i at [DW*i+DW-1:DW*i]
//  ch_auth_en   in   NUM_CH     per-channel authorisation from PUF control; sampled at accept
//  eng_start    out  1          one-cycle engine launch pulse
//  eng_op       out  2          captured op, stable from ISSUE through WAIT
//  eng_data     out  DW         captured payload, stable from ISSUE through WAIT
//  eng_abort    out  1          one-cycle pulse on timeout
//  eng_done     in   1          engine completion pulse
//  eng_result   in   DW         engine result, valid with eng_done
//  rsp_valid    out  1          response valid
//  rsp_ready    in   1          response consumer ready
//  rsp_ch       out  CW         channel the response belongs to
//  rsp_status   out  2          00 OK, 01 DENIED, 10 TIMEOUT, 11 BAD_OP
//  rsp_data     out  DW         eng_result on OK, else 0
//  busy         out  1          high in any state other than IDLE
//  err_cnt      out  8          saturating count of non-OK responses delivered
// BEHAVIOUR
//  Reset (nreset=0, async): state=IDLE; rr_ptr=NUM_CH-1; all outputs 0; capture regs and timer 0.
//  A reset mid-transaction drops that transaction silently; the engine is reset by its own path.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on DENIED or BAD_OP.
//  IDLE:
//   - Winner = first channel with req_valid, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
//   - req_ready[winner]=1 combinationally in the same cycle; capture op, data, ch and auth at that edge.
//   - No req_valid: stay in IDLE with req_ready=0.
//   - Dispatch at capture: !auth -> RESP/DENIED; else op==11 -> RESP/BAD_OP; else -> ISSUE.
//   - DENIED takes precedence over BAD_OP.
//  ISSUE: eng_start=1 for exactly this cycle; timer<=0; -> WAIT.
//  WAIT:
//   - eng_done=1: latch eng_result, status OK -> RESP.
//   - Else if timer==TIMEOUT_CYC-1: status TIMEOUT, data 0, eng_abort=1 this cycle -> RESP.
//   - Else timer++. eng_done and timeout in the same cycle: done wins.
//  RESP:
//   - rsp_valid=1; rsp_ch, rsp_status and rsp_data held stable until rsp_valid && rsp_ready.
//   - On that handshake: rr_ptr<=rsp_ch; err_cnt++ if status!=OK (saturates at 255); -> IDLE.
//  eng_done outside WAIT is ignored. req_ready=0 outside IDLE. Back-to-back: the next accept is the
//   cycle after the RESP handshake.
//  Latency: accept at cycle T -> eng_start at T+1 -> eng_done at D -> rsp_valid at D+1.
//   DENIED or BAD_OP: rsp_valid at T+1.
//  Timer width is $clog2(TIMEOUT_CYC); no wrap is possible because the timer is cleared in ISSUE.
// TESTING
//  1 ch0 HASH, auth=1, data=128'hA5, eng_done at 5 cycles with result=128'h1234 -> one eng_start
//    pulse with eng_op=00; rsp ch=0 status=00 data=128'h1234.
//  2 All 4 ch valid and auth, engine 2-cycle done -> grants 0,1,2,3,0 in order; at most one
//    req_ready bit high per cycle.
//  3 ch2 auth=0, op=01 -> no eng_start; rsp_valid next cycle, ch=2, status=01, data=0; err_cnt=1.
//  4 ch1 op=11, auth=1 -> status=11 without engine start. Same with auth=0 -> status=01 (precedence).
//  5 TIMEOUT_CYC=8, engine never responds -> eng_abort exactly 8 cycles after eng_start is
//    sampled; status=10; err_cnt increments.
//  6 rsp_ready held low 10 cycles -> rsp fields stable and no new accept. nreset pulsed in WAIT ->
//    all outputs 0 immediately; after release, ch0 wins first.

Source files
------------

// File: rtl/sec_engine_scheduler.sv
// sec_engine_scheduler
//   Multi-channel front end for the shared crypto engine (SHA256 / Camellia).
//   Round-robin arbitrates NUM_CH requesters. Each request is gated on its channel's
//   PUF authorisation bit. One start/done transaction at a time goes to the engine,
//   under a timeout watchdog. Every request gets a tagged response with a status code.
//   Non-OK responses are counted in a saturating counter.
//
// Ports
//   clk, nreset              clock; asynchronous active-low reset
//   req_valid / req_ready    per-channel request handshake (req_ready one-hot or zero)
//   req_op, req_data         per-channel op (2b) and payload (DW); channel i in slice i
//   ch_auth_en               per-channel authorisation, sampled at accept
//   eng_start / eng_abort    one-cycle engine launch / timeout-abort pulses
//   eng_op, eng_data         captured request, stable from launch through the wait
//   eng_done, eng_result     engine completion pulse and its result
//   rsp_valid / rsp_ready    response handshake
//   rsp_ch, rsp_status,      response tag, status (00 OK, 01 DENIED, 10 TIMEOUT,
//   rsp_data                 11 BAD_OP) and data (result on OK, else 0)
//   busy                     any state other than IDLE
//   err_cnt                  saturating count of delivered non-OK responses
//
// state | meaning
// IDLE  | arbitrate; accept the winner and dispatch on auth/op
// ISSUE | pulse eng_start, clear the watchdog timer
// WAIT  | wait for eng_done or watchdog expiry
// RESP  | hold the response until rsp_ready
module sec_engine_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int DW          = 128,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CW         = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [NUM_CH-1:0]    req_valid,
  output logic [NUM_CH-1:0]    req_ready,
  input  logic [2*NUM_CH-1:0]  req_op,
  input  logic [DW*NUM_CH-1:0] req_data,
  input  logic [NUM_CH-1:0]    ch_auth_en,
  output logic                 eng_start,
  output logic [1:0]           eng_op,
  output logic [DW-1:0]        eng_data,
  output logic                 eng_abort,
  input  logic                 eng_done,
  input  logic [DW-1:0]        eng_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CW-1:0]        rsp_ch,
  output logic [1:0]           rsp_status,
  output logic [DW-1:0]        rsp_data,
  output logic                 busy,
  output logic [7:0]           err_cnt
);

  localparam int            TW     = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DENIED  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BAD_OP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [1:0]      op_q, op_d;
  logic [DW-1:0]   data_q, data_d;
  logic [1:0]      status_q, status_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  // Round-robin search starting one past the last served channel.
  logic            found;
  logic [CW-1:0]   winner;
  logic [CW-1:0]   idx;
  logic [1:0]      win_op;
  logic [DW-1:0]   win_data;
  logic            win_auth;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    idx      = '0;
    win_op   = '0;
    win_data = '0;
    win_auth = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CW'((int'(rr_ptr_q) + k) % NUM_CH);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        winner   = idx;
        win_op   = req_op[2*idx +: 2];
        win_data = req_data[DW*idx +: DW];
        win_auth = ch_auth_en[idx];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    ch_d       = ch_q;
    op_d       = op_q;
    data_d     = data_q;
    status_d   = status_q;
    rsp_data_d = rsp_data_q;
    timer_d    = timer_q;
    err_cnt_d  = err_cnt_q;
    req_ready  = '0;
    eng_start  = 1'b0;
    eng_abort  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          ch_d       = winner;
          op_d       = win_op;
          data_d     = win_data;
          rsp_data_d = '0;
          // Authorisation is checked first so an unauthorised channel learns nothing
          // about op validity.
          if (!win_auth) begin
            status_d = ST_DENIED;
            state_d  = S_RESP;
          end else if (win_op == 2'b11) begin
            status_d = ST_BAD_OP;
            state_d  = S_RESP;
          end else begin
            status_d = ST_OK;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        eng_start = 1'b1;
        timer_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // A completion arriving on the last allowed cycle still counts.
        if (eng_done) begin
          status_d   = ST_OK;
          rsp_data_d = eng_result;
          state_d    = S_RESP;
        end else if (timer_q == T_LAST) begin
          status_d   = ST_TIMEOUT;
          rsp_data_d = '0;
          eng_abort  = 1'b1;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = ch_q;
          if (status_q != ST_OK && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= CW'(NUM_CH - 1);
      ch_q       <= '0;
      op_q       <= '0;
      data_q     <= '0;
      status_q   <= '0;
      rsp_data_q <= '0;
      timer_q    <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      ch_q       <= ch_d;
      op_q       <= op_d;
      data_q     <= data_d;
      status_q   <= status_d;
      rsp_data_q <= rsp_data_d;
      timer_q    <= timer_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign eng_op     = op_q;
  assign eng_data   = data_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_ch     = ch_q;
  assign rsp_status = status_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q != S_IDLE);
  assign err_cnt    = err_cnt_q;

endmodule
